// File: rtl/md_unit.sv
// E-stage multiply/divide unit: holds architectural HI/LO, computes the result at
// start and commits it after a fixed MULT_CYCLES/DIV_CYCLES latency.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hiwrite,
    input  logic        lowrite,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_skip;

    logic [63:0]        prod_u;
    logic signed [63:0] prod_s;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        den;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic               div_zero;
    logic [31:0]        calc_hi;
    logic [31:0]        calc_lo;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
    always_comb begin
        sgn      = ~mdop[0];
        prod_u   = {32'b0, a} * {32'b0, b};
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        a_neg    = sgn & a[31];
        b_neg    = sgn & b[31];
        a_mag    = a_neg ? (32'd0 - a) : a;
        b_mag    = b_neg ? (32'd0 - b) : b;
        div_zero = (b == '0);
        den      = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / den;
        r_mag    = a_mag % den;
        quo      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
        calc_hi  = '0;
        calc_lo  = '0;
        case (mdop)
            2'b00: begin
                calc_hi = prod_s[63:32];
                calc_lo = prod_s[31:0];
            end
            2'b01: begin
                calc_hi = prod_u[63:32];
                calc_lo = prod_u[31:0];
            end
            default: begin
                calc_hi = rem;
                calc_lo = quo;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            res_skip <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        res_hi   <= calc_hi;
                        res_lo   <= calc_lo;
                        res_skip <= mdop[1] & div_zero;
                        cnt      <= mdop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        if (hiwrite) hi <= a;
                        if (lowrite) lo <= a;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!res_skip) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign md_stall = start | busy;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a time-stamped behavioural model checked every cycle,
// plus literal expectations for each directed operation.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [1:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        hiwrite;
    logic        lowrite;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks      = 0;
    int failures    = 0;
    int busy_cycles = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .clr(clr), .start(start), .mdop(mdop), .a(a), .b(b),
        .hiwrite(hiwrite), .lowrite(lowrite), .busy(busy), .md_stall(md_stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start schedules its result for edge index start_edge + latency.
    int          cyc = 0;
    int          commit_edge = 0;
    logic        m_busy = 1'b0;
    logic        m_skip = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0;
        end else begin
            longint      sa, sb;
            logic [63:0] up;
            cyc++;
            if (m_busy) begin
                if (cyc == commit_edge) begin
                    if (!m_skip) begin m_hi = p_hi; m_lo = p_lo; end
                    m_busy = 1'b0;
                end
            end else if (start) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                m_skip = 1'b0;
                case (mdop)
                    2'd0: begin up = 64'(sa * sb); p_hi = up[63:32]; p_lo = up[31:0]; end
                    2'd1: begin up = 64'(a) * 64'(b); p_hi = up[63:32]; p_lo = up[31:0]; end
                    2'd2: if (b == 0) m_skip = 1'b1;
                          else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
                    default: if (b == 0) m_skip = 1'b1;
                             else begin p_lo = a / b; p_hi = a % b; end
                endcase
                commit_edge = cyc + (mdop[1] ? 10 : 5);
                m_busy = 1'b1;
            end else begin
                if (hiwrite) m_hi = a;
                if (lowrite) m_lo = a;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (m_busy) busy_cycles++;
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_md_stall", 32'(md_stall), 32'(start | m_busy));
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic go(input logic [1:0] op, input logic [31:0] oa, input logic [31:0] ob,
                      input logic lw);
        @(negedge clk);
        mdop = op; a = oa; b = ob; start = 1'b1; lowrite = lw;
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b0; lowrite = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic finish_op(input string name, input int n, input logic [31:0] ehi,
                             input logic [31:0] elo);
        int guard = 0;
        while (busy && guard < 60) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (guard >= 60) chk({name, "_timeout"}, 32'(busy), 32'd0);
        chk({name, "_busy_cycles"}, 32'(busy_cycles), 32'(n));
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b0; start = 1'b0; mdop = '0; a = '0; b = '0; hiwrite = 1'b0; lowrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; mdop = 2'($urandom_range(0, 3));
            start = 1'($urandom_range(0, 1));
            hiwrite = 1'($urandom_range(0, 1)); lowrite = 1'($urandom_range(0, 1));
        end
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; hiwrite = 1'b0; lowrite = 1'b0; a = '0; b = '0; mdop = '0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("post_reset_hi", hi, 32'h0);
        chk("post_reset_lo", lo, 32'h0);

        go(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        finish_op("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        go(2'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        finish_op("multu", 5, 32'h0000_0002, 32'hFFFF_FFFA);
        go(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        finish_op("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        go(2'd3, 32'd7, 32'd2, 1'b0);
        finish_op("divu", 10, 32'd1, 32'd3);
        go(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        finish_op("div_ovf", 10, 32'h0, 32'h8000_0000);

        @(negedge clk); hiwrite = 1'b1; a = 32'h1234;
        @(negedge clk); hiwrite = 1'b0; lowrite = 1'b1; a = 32'h5678;
        @(negedge clk); lowrite = 1'b0;
        #1;
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);
        go(2'd3, 32'h0000_00AB, 32'h0, 1'b0);
        finish_op("divu_zero", 10, 32'h1234, 32'h5678);

        go(2'd0, 32'd6, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk); hiwrite = 1'b1; a = 32'hDEAD;
        @(negedge clk); hiwrite = 1'b0;
        finish_op("hiwrite_in_run", 5, 32'h0, 32'd42);

        go(2'd0, 32'd5, 32'd5, 1'b1);
        finish_op("start_lowrite", 5, 32'h0, 32'd25);

        go(2'd0, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        @(negedge clk); mdop = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        finish_op("start_in_run", 5, 32'h0, 32'd12);

        @(negedge clk); hiwrite = 1'b1; lowrite = 1'b1; a = 32'hCAFE_BABE;
        @(negedge clk); hiwrite = 1'b0; lowrite = 1'b0;
        #1;
        chk("both_wr_hi", hi, 32'hCAFE_BABE);
        chk("both_wr_lo", lo, 32'hCAFE_BABE);

        go(2'd2, 32'd100, 32'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk); clr = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("no_late_hi", hi, 32'h0);
        chk("no_late_lo", lo, 32'h0);
        chk("no_late_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
